// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID register, 32x32 register file with
// write-through bypass, main control decoder and load-use hazard detection.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_add4,
    input  logic        flush,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] add4,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic [31:0] sign_ext,
    output logic [1:0]  wb,
    output logic [2:0]  m,
    output logic [3:0]  ex,
    output logic        pc_write,
    output logic        stall
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [31:0] instr_q, instr_d;
    logic [31:0] add4_q, add4_d;
    logic [31:0] regs_q [32];

    logic [1:0] wb_dec;
    logic [2:0] m_dec;
    logic [3:0] ex_dec;

    // A same-cycle WB write to the addressed register is forwarded.
    function automatic logic [31:0] rf_read(input logic [4:0] addr,
                                            input logic [31:0] stored,
                                            input logic we,
                                            input logic [4:0] waddr,
                                            input logic [31:0] wdata);
        logic [31:0] val;
        if (addr == 5'd0)
            val = 32'd0;
        else if (we && (waddr == addr))
            val = wdata;
        else
            val = stored;
        return val;
    endfunction

    always_comb begin
        instr_d = instr_q;
        add4_d  = add4_q;
        if (flush) begin
            instr_d = 32'd0;
            add4_d  = 32'd0;
        end else if (!stall) begin
            instr_d = if_instr;
            add4_d  = if_add4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= 32'd0;
            add4_q  <= 32'd0;
        end else begin
            instr_q <= instr_d;
            add4_q  <= add4_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= 32'd0;
        end else if (wb_we && (wb_addr != 5'd0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign rd       = instr_q[15:11];
    assign add4     = add4_q;
    assign sign_ext = {{16{instr_q[15]}}, instr_q[15:0]};

    assign read_data1 = rf_read(rs, regs_q[rs], wb_we, wb_addr, wb_data);
    assign read_data2 = rf_read(rt, regs_q[rt], wb_we, wb_addr, wb_data);

    assign stall    = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == rs) || (idex_rt == rt));
    assign pc_write = ~stall;

    always_comb begin
        wb_dec = 2'b00;
        m_dec  = 3'b000;
        ex_dec = 4'b0000;
        unique case (instr_q[31:26])
            OP_RTYPE: begin wb_dec = 2'b10; m_dec = 3'b000; ex_dec = 4'b1100; end
            OP_LW:    begin wb_dec = 2'b11; m_dec = 3'b010; ex_dec = 4'b0001; end
            OP_SW:    begin wb_dec = 2'b00; m_dec = 3'b001; ex_dec = 4'b0001; end
            OP_BEQ:   begin wb_dec = 2'b00; m_dec = 3'b100; ex_dec = 4'b0010; end
            OP_ADDI:  begin wb_dec = 2'b10; m_dec = 3'b000; ex_dec = 4'b0001; end
            default:  begin wb_dec = 2'b00; m_dec = 3'b000; ex_dec = 4'b0000; end
        endcase
    end

    // Bubble into ID/EX while a load-use hazard holds IF/ID.
    assign wb = stall ? 2'b00   : wb_dec;
    assign m  = stall ? 3'b000  : m_dec;
    assign ex = stall ? 4'b0000 : ex_dec;

endmodule
